slice_phase_ctrl: RTL
=====================

# slice_phase_ctrl

Per-slice phase controller for the ProRes encoder pipeline. On a slice start it latches the slice's block count, then drives three phases in order through a state machine: DCT fill, DC VLC, and AC VLC. Phase lengths are derived from the block count and fixed stage latencies. It adds busy/done handshaking, start-error reporting, abort, and a slice counter. It sits between the slice fetch logic and the DCT / DC VLC / AC VLC stages.

## Interface
Parameters:
- DCT_TIME, 12, DCT pipeline latency in cycles before DC VLC may run
- DC_VLC_TIME, 44, DC VLC phase length in cycles
- AC_TAIL, 5, extra AC VLC cycles beyond 63 per block
- MAX_BLOCKS, 64, largest legal block_num

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- slice_start  in  1  one-cycle start request
- block_num  in  32  blocks in the slice; sampled only when slice_start is accepted
- abort  in  1  synchronous abort of the current slice
- busy  out  1  slice in progress (any state other than IDLE)
- slice_done  out  1  one-cycle pulse on normal completion
- start_err  out  1  one-cycle pulse when slice_start is rejected
- phase  out  3  IDLE=0, DCT=1, DC_VLC=2, AC_VLC=3, DONE=4
- phase_counter  out  32  cycles elapsed in the current phase, 0 on entry
- dct_enable  out  1  high throughout DCT
- dc_vlc_reset  out  1  active-low stage reset; high (run) only in DC_VLC
- ac_vlc_reset  out  1  active-low stage reset; high (run) only in AC_VLC
- slice_count  out  16  completed slices; wraps at 16 bits

## Operation
- Reset (reset_n low) forces all outputs to 0, phase to IDLE, and the latched block count to 0.
- IDLE: on slice_start, if 1 ≤ block_num ≤ MAX_BLOCKS, latch the count as B and go to DCT. Otherwise pulse start_err and stay in IDLE.
- DCT: lasts DCT_TIME+B cycles, then go to DC_VLC.
- DC_VLC: lasts DC_VLC_TIME cycles, then go to AC_VLC.
- AC_VLC: lasts 63·B+AC_TAIL cycles, then go to DONE.
- DONE: lasts 1 cycle. slice_done=1, slice_count increments, then go to IDLE.
- slice_start outside IDLE (including the DONE cycle) is rejected: start_err pulses and current operation is unaffected.
- abort in any non-IDLE state: next cycle is IDLE, phase_counter=0, all stage controls low. No slice_done and no slice_count change. abort in IDLE has no effect.
- If abort and slice_start are asserted in the same cycle:
  - non-IDLE: abort wins and start_err pulses.
  - IDLE: the start is evaluated normally.
- Arithmetic:
  - Phase lengths are computed once at acceptance, in 32 bits.
  - 63·B is computed as (B<<6)−B. With B ≤ MAX_BLOCKS this cannot overflow.
  - Phase exit happens when phase_counter equals length−1.
- block_num changes after acceptance are ignored.

## Timing
- All outputs are registered.
- Start accepted at edge T: cycle T+1 begins DCT with phase_counter=0 and busy=1.
- dct_enable is high for cycles T+1 … T+DCT_TIME+B.
- dc_vlc_reset is high for the next DC_VLC_TIME cycles.
- ac_vlc_reset is high for the following 63·B+AC_TAIL cycles.
- slice_done is high for the single cycle after that. busy falls one cycle later.
- Total busy span per slice: DCT_TIME+DC_VLC_TIME+64·B+AC_TAIL+1 cycles.
- Earliest next accepted start is the first IDLE cycle, so consecutive slices have no overlap.
- start_err appears the cycle after the offending slice_start.
- Asserting reset_n low mid-slice clears state immediately (asynchronous). The next slice_start after reset release is accepted normally.

## Structure
- Package slice_seq_pkg holds:
  - the phase enum (codes above)
  - default constants DCT_TIME, DC_VLC_TIME, AC_TAIL, MAX_BLOCKS
  - the 32-bit count type
- Sub-module phase_timer: loadable 32-bit up-counter.
  - Inputs: load, length, clear.
  - Outputs: count and a terminal flag (count==length−1).
  - Instantiated once and reloaded on every phase entry.
- The FSM, length computation, and slice counter live in slice_phase_ctrl.

## Test plan
- Reset then start with B=8 → dct_enable for 20 cycles, dc_vlc_reset for 44, ac_vlc_reset for 509. slice_done at T+574. slice_count=1.
- B=0, then B=65 → start_err pulse each time, busy stays 0, no phase change.
- slice_start during AC_VLC and during DONE → start_err pulse; slice timing is identical to the undisturbed run.
- abort on cycle 30 of DC_VLC (B=1) → IDLE next cycle, all controls 0, no slice_done. A new start with B=1 completes in 13+44+68+1=126 busy cycles.
- reset_n low mid-DCT → outputs 0 immediately. After release, start with B=64 → ac_vlc_reset high for 4037 cycles.
- 65536 back-to-back B=1 slices (or force slice_count to 0xFFFF) → slice_count wraps to 0.

Source files
------------

// File: rtl/slice_seq_pkg.sv
// Shared types and default timing constants for the slice phase controller.
package slice_seq_pkg;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned PHASE_W     = 3;
    localparam int unsigned SLICE_CNT_W = 16;

    localparam int unsigned DEF_DCT_TIME    = 12;
    localparam int unsigned DEF_DC_VLC_TIME = 44;
    localparam int unsigned DEF_AC_TAIL     = 5;
    localparam int unsigned DEF_MAX_BLOCKS  = 64;

    typedef logic [CNT_W-1:0]       count_t;
    typedef logic [SLICE_CNT_W-1:0] slice_cnt_t;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE   = 3'd0,
        PH_DCT    = 3'd1,
        PH_DC_VLC = 3'd2,
        PH_AC_VLC = 3'd3,
        PH_DONE   = 3'd4
    } phase_e;

    // AC VLC phase length: 63 cycles per block plus a fixed tail, 63*B done as (B<<6)-B
    function automatic count_t ac_vlc_len(input count_t blocks, input int unsigned tail);
        return (blocks << 6) - blocks + CNT_W'(tail);
    endfunction

endpackage

// File: rtl/slice_phase_ctrl_if.sv
// Slice fetch <-> phase controller handshake and stage-control bundle.
interface slice_phase_ctrl_if;
    import slice_seq_pkg::*;

    logic       slice_start;
    count_t     block_num;
    logic       abort;

    logic       busy;
    logic       slice_done;
    logic       start_err;
    phase_e     phase;
    count_t     phase_counter;
    logic       dct_enable;
    logic       dc_vlc_reset;
    logic       ac_vlc_reset;
    slice_cnt_t slice_count;

    modport master (
        output slice_start, block_num, abort,
        input  busy, slice_done, start_err, phase, phase_counter,
               dct_enable, dc_vlc_reset, ac_vlc_reset, slice_count
    );

    modport slave (
        input  slice_start, block_num, abort,
        output busy, slice_done, start_err, phase, phase_counter,
               dct_enable, dc_vlc_reset, ac_vlc_reset, slice_count
    );

endinterface

// File: rtl/slice_phase_ctrl_phase_timer.sv
// Loadable 32-bit up-counter timing one phase; terminal when count reaches length-1.
module phase_timer
    import slice_seq_pkg::*;
(
    input  logic   clock,
    input  logic   reset_n,
    input  logic   load,
    input  logic   clear,
    input  count_t length,
    output count_t count,
    output logic   terminal_c
);

    count_t length_q;

    // load restarts at 0 with a new length; clear holds at 0 without touching the length
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            length_q <= '0;
        end else if (load) begin
            count    <= '0;
            length_q <= length;
        end else if (clear) begin
            count    <= '0;
        end else begin
            count    <= count + CNT_W'(1);
        end
    end

    assign terminal_c = (count == (length_q - CNT_W'(1)));

endmodule

// File: rtl/slice_phase_ctrl.sv
// Per-slice phase sequencer: DCT fill, DC VLC, AC VLC, then a one-cycle DONE.
module slice_phase_ctrl
    import slice_seq_pkg::*;
#(
    parameter int unsigned DCT_TIME    = DEF_DCT_TIME,
    parameter int unsigned DC_VLC_TIME = DEF_DC_VLC_TIME,
    parameter int unsigned AC_TAIL     = DEF_AC_TAIL,
    parameter int unsigned MAX_BLOCKS  = DEF_MAX_BLOCKS
) (
    input  logic               clock,
    input  logic               reset_n,
    slice_phase_ctrl_if.slave  sp
);

    phase_e     state_q;
    phase_e     state_d;
    count_t     ac_len_q;
    count_t     ac_len_d;
    logic       start_err_q;
    logic       start_err_d;
    logic       slice_done_q;
    logic       busy_q;
    logic       dct_enable_q;
    logic       dc_vlc_run_q;
    logic       ac_vlc_run_q;
    slice_cnt_t slice_count_q;
    logic       count_inc;

    logic       tmr_load;
    logic       tmr_clear;
    count_t     tmr_len;
    count_t     tmr_count;
    logic       tmr_term_c;
    logic       block_ok_c;

    assign block_ok_c = (sp.block_num != '0) && (sp.block_num <= CNT_W'(MAX_BLOCKS));

    phase_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .clear      (tmr_clear),
        .length     (tmr_len),
        .count      (tmr_count),
        .terminal_c (tmr_term_c)
    );

    // Next-state, timer control and pulse decode
    always_comb begin
        state_d     = state_q;
        ac_len_d    = ac_len_q;
        tmr_load    = 1'b0;
        tmr_clear   = 1'b0;
        tmr_len     = '0;
        start_err_d = 1'b0;
        count_inc   = 1'b0;

        if (state_q == PH_IDLE) begin
            // abort is meaningless in IDLE, so a start here is judged on block_num alone
            tmr_clear = 1'b1;
            if (sp.slice_start) begin
                if (block_ok_c) begin
                    state_d  = PH_DCT;
                    tmr_load = 1'b1;
                    tmr_len  = CNT_W'(DCT_TIME) + sp.block_num;
                    ac_len_d = ac_vlc_len(sp.block_num, AC_TAIL);
                end else begin
                    start_err_d = 1'b1;
                end
            end
        end else begin
            start_err_d = sp.slice_start;
            if (sp.abort) begin
                state_d   = PH_IDLE;
                tmr_clear = 1'b1;
            end else begin
                case (state_q)
                    PH_DCT: begin
                        if (tmr_term_c) begin
                            state_d  = PH_DC_VLC;
                            tmr_load = 1'b1;
                            tmr_len  = CNT_W'(DC_VLC_TIME);
                        end
                    end
                    PH_DC_VLC: begin
                        if (tmr_term_c) begin
                            state_d  = PH_AC_VLC;
                            tmr_load = 1'b1;
                            tmr_len  = ac_len_q;
                        end
                    end
                    PH_AC_VLC: begin
                        if (tmr_term_c) begin
                            state_d  = PH_DONE;
                            tmr_load = 1'b1;
                            tmr_len  = CNT_W'(1);
                        end
                    end
                    PH_DONE: begin
                        state_d   = PH_IDLE;
                        tmr_clear = 1'b1;
                        count_inc = 1'b1;
                    end
                    default: begin
                        state_d   = PH_IDLE;
                        tmr_clear = 1'b1;
                    end
                endcase
            end
        end
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= PH_IDLE;
            ac_len_q      <= '0;
            start_err_q   <= 1'b0;
            slice_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            dct_enable_q  <= 1'b0;
            dc_vlc_run_q  <= 1'b0;
            ac_vlc_run_q  <= 1'b0;
            slice_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ac_len_q      <= ac_len_d;
            start_err_q   <= start_err_d;
            slice_done_q  <= (state_d == PH_DONE);
            busy_q        <= (state_d != PH_IDLE);
            dct_enable_q  <= (state_d == PH_DCT);
            dc_vlc_run_q  <= (state_d == PH_DC_VLC);
            ac_vlc_run_q  <= (state_d == PH_AC_VLC);
            slice_count_q <= slice_count_q + SLICE_CNT_W'(count_inc);
        end
    end

    assign sp.phase         = state_q;
    assign sp.phase_counter = tmr_count;
    assign sp.busy          = busy_q;
    assign sp.slice_done    = slice_done_q;
    assign sp.start_err     = start_err_q;
    assign sp.dct_enable    = dct_enable_q;
    assign sp.dc_vlc_reset  = dc_vlc_run_q;
    assign sp.ac_vlc_reset  = ac_vlc_run_q;
    assign sp.slice_count   = slice_count_q;

endmodule
